// File: rtl/mc_pkg.sv
// Shared definitions for the windowed compare-statistics block.
//   mc_state_e : FSM encoding (ACCUM = collecting pairs, HOLD = result pending)
//   MC_WIDTH / MC_WIN / MC_CNT_W : default parameter values for mc_window_stats
package mc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } mc_state_e;

   localparam int MC_WIDTH = 4;
   localparam int MC_WIN   = 8;
   localparam int MC_CNT_W = 8;

endpackage : mc_pkg

// File: rtl/mc_cmp_core.sv
// Unsigned magnitude compare of two operands. Exactly one output is high.
// Ports:
//   a, b : operands (WIDTH bits, unsigned)
//   gt   : a > b
//   eq   : a == b
//   lt   : a < b
module mc_cmp_core #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   always_comb begin
      gt = (a > b);
      eq = (a == b);
      lt = (a < b);
   end

endmodule : mc_cmp_core

// File: rtl/mc_window_stats.sv
// Windowed compare statistics. Accepts WIN operand pairs, counts how many
// had a>b, a==b and a<b (and optionally the largest a), then holds the
// result until the consumer takes it.
//
// Optional feature: define MC_WINDOW_MAX_EN to track max_a; otherwise max_a
// is tied to zero and no tracking register exists.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   in_valid   : operand pair valid       in_ready : pair accepted this cycle
//   a, b       : operands
//   clear      : discard the partial window (ignored while a result is held)
//   out_valid  : window result valid      out_ready : consumer takes result
//   gt_cnt, eq_cnt, lt_cnt : per-window compare counts
//   max_a      : largest a of the window
//
// state | meaning
// ------+--------------------------------------------------------------
// ACCUM | collecting pairs; counts are running totals
// HOLD  | WIN pairs collected; result frozen until out_ready
module mc_window_stats
   import mc_pkg::*;
#(
   parameter int WIDTH = MC_WIDTH,
   parameter int WIN   = MC_WIN,
   parameter int CNT_W = MC_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [WIDTH-1:0] max_a
);

   if ((WIN < 1) || (WIN > 255) || (WIN > (2 ** CNT_W) - 1)) begin : g_bad_params
      $error("mc_window_stats: WIN must be 1..255 and fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);

   mc_state_e        state_q, state_d;
   logic [CNT_W-1:0] gt_q, gt_d;
   logic [CNT_W-1:0] eq_q, eq_d;
   logic [CNT_W-1:0] lt_q, lt_d;
   logic [CNT_W-1:0] smp_q, smp_d;

   logic cmp_gt, cmp_eq, cmp_lt;
   logic take;       // pair counted this edge (clear wins over accept)
   logic win_zero;   // window contents discarded this edge

   mc_cmp_core #(.WIDTH(WIDTH)) u_cmp (
      .a  (a),
      .b  (b),
      .gt (cmp_gt),
      .eq (cmp_eq),
      .lt (cmp_lt)
   );

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);

   assign take     = in_valid && (state_q == ACCUM) && !clear;
   assign win_zero = ((state_q == ACCUM) && clear) || ((state_q == HOLD) && out_ready);

   always_comb begin
      state_d = state_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      smp_d   = smp_q;
      if (win_zero) begin
         gt_d  = '0;
         eq_d  = '0;
         lt_d  = '0;
         smp_d = '0;
         if (state_q == HOLD) begin
            state_d = ACCUM;
         end
      end else if (take) begin
         gt_d  = gt_q + CNT_W'(cmp_gt);
         eq_d  = eq_q + CNT_W'(cmp_eq);
         lt_d  = lt_q + CNT_W'(cmp_lt);
         smp_d = smp_q + CNT_W'(1);
         if (smp_q == LAST_IDX) begin
            state_d = HOLD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ACCUM;
         gt_q    <= '0;
         eq_q    <= '0;
         lt_q    <= '0;
         smp_q   <= '0;
      end else begin
         state_q <= state_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         smp_q   <= smp_d;
      end
   end

   assign gt_cnt = gt_q;
   assign eq_cnt = eq_q;
   assign lt_cnt = lt_q;

`ifdef MC_WINDOW_MAX_EN
   logic [WIDTH-1:0] max_q, max_d;

   // First sample of a window loads unconditionally so no stale value leaks in.
   always_comb begin
      max_d = max_q;
      if (win_zero) begin
         max_d = '0;
      end else if (take && ((smp_q == '0) || (a > max_q))) begin
         max_d = a;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         max_q <= '0;
      end else begin
         max_q <= max_d;
      end
   end

   assign max_a = max_q;
`else
   assign max_a = '0;
`endif

endmodule : mc_window_stats

// File: tb/tb_mc_window_stats.sv
module tb_mc_window_stats;

`ifdef MC_WINDOW_MAX_EN
   localparam bit MAXON = 1'b1;
`else
   localparam bit MAXON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, clear, out_valid, out_ready;
   logic [3:0] a, b, max_a;
   logic [7:0] gt_cnt, eq_cnt, lt_cnt;

   // WIN=1 instance for the single-sample window boundary
   logic       w1_valid, w1_ready, w1_ovalid, w1_oready;
   logic [3:0] w1_a, w1_b, w1_max;
   logic [7:0] w1_gt, w1_eq, w1_lt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mc_window_stats #(.WIDTH(4), .WIN(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
      .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .max_a(max_a)
   );

   mc_window_stats #(.WIDTH(4), .WIN(1), .CNT_W(8)) dut_w1 (
      .clk(clk), .rst(rst), .in_valid(w1_valid), .in_ready(w1_ready),
      .a(w1_a), .b(w1_b), .clear(1'b0), .out_valid(w1_ovalid), .out_ready(w1_oready),
      .gt_cnt(w1_gt), .eq_cnt(w1_eq), .lt_cnt(w1_lt), .max_a(w1_max)
   );

   typedef struct {
      logic       iv;
      logic [3:0] va;
      logic [3:0] vb;
      logic       clr;
      logic       ordy;
      logic       e_ir;
      logic       e_ov;
      int         e_gt;
      int         e_eq;
      int         e_lt;
      int         e_max;
   } vec_t;

   vec_t vt[21];

   function automatic vec_t mk(logic iv, int va, int vb, logic clr, logic ordy,
                               logic e_ir, logic e_ov, int e_gt, int e_eq, int e_lt, int e_max);
      vec_t v;
      v.iv = iv; v.va = 4'(va); v.vb = 4'(vb); v.clr = clr; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_gt = e_gt; v.e_eq = e_eq; v.e_lt = e_lt;
      v.e_max = MAXON ? e_max : 0;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic chk_all(string tag, int e_ir, int e_ov, int e_gt, int e_eq, int e_lt, int e_max);
      chk({tag, ".in_ready"},  int'(in_ready),  e_ir);
      chk({tag, ".out_valid"}, int'(out_valid), e_ov);
      chk({tag, ".gt_cnt"},    int'(gt_cnt),    e_gt);
      chk({tag, ".eq_cnt"},    int'(eq_cnt),    e_eq);
      chk({tag, ".lt_cnt"},    int'(lt_cnt),    e_lt);
      chk({tag, ".max_a"},     int'(max_a),     e_max);
   endtask

   // Offer one pair, waiting (bounded) for in_ready; returns at the negedge after the accept.
   task automatic push(int pa, int pb);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk("push.in_ready_timeout", 0, 1);
      in_valid = 1'b1; a = 4'(pa); b = 4'(pb);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int mg, me, ml, mm, n;

      // iv a b clr ordy | ir ov gt eq lt max   (expected = outputs before this edge)
      vt[0]  = mk(1, 9, 3, 0, 0,  1, 0, 0, 0, 0, 0);
      vt[1]  = mk(1, 5, 5, 0, 0,  1, 0, 1, 0, 0, 9);
      vt[2]  = mk(1, 2, 7, 0, 0,  1, 0, 1, 1, 0, 9);
      vt[3]  = mk(1,15, 0, 0, 0,  1, 0, 1, 1, 1, 9);
      vt[4]  = mk(1, 1, 2, 0, 0,  0, 1, 2, 1, 1, 15);
      vt[5]  = mk(1, 1, 2, 0, 0,  0, 1, 2, 1, 1, 15);
      vt[6]  = mk(1, 1, 2, 0, 0,  0, 1, 2, 1, 1, 15);
      vt[7]  = mk(1, 1, 2, 0, 0,  0, 1, 2, 1, 1, 15);
      vt[8]  = mk(1, 1, 2, 0, 0,  0, 1, 2, 1, 1, 15);
      vt[9]  = mk(1, 1, 2, 0, 1,  0, 1, 2, 1, 1, 15);
      vt[10] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      vt[11] = mk(1, 1, 2, 0, 0,  1, 0, 0, 0, 0, 0);
      vt[12] = mk(1, 3, 1, 0, 0,  1, 0, 0, 0, 1, 1);
      vt[13] = mk(1, 3, 3, 1, 0,  1, 0, 1, 0, 1, 3);
      vt[14] = mk(1, 4, 4, 0, 0,  1, 0, 0, 0, 0, 0);
      vt[15] = mk(1, 6, 2, 0, 0,  1, 0, 0, 1, 0, 4);
      vt[16] = mk(1, 0, 8, 0, 0,  1, 0, 1, 1, 0, 6);
      vt[17] = mk(1, 7, 7, 0, 0,  1, 0, 1, 1, 1, 6);
      vt[18] = mk(0, 0, 0, 1, 0,  0, 1, 1, 2, 1, 7);
      vt[19] = mk(0, 0, 0, 0, 1,  0, 1, 1, 2, 1, 7);
      vt[20] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);

      rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; clear = 1'b0; out_ready = 1'b0;
      w1_valid = 1'b0; w1_a = '0; w1_b = '0; w1_oready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), vt[i].e_ir, vt[i].e_ov, vt[i].e_gt,
                 vt[i].e_eq, vt[i].e_lt, vt[i].e_max);
         in_valid = vt[i].iv; a = vt[i].va; b = vt[i].vb;
         clear = vt[i].clr; out_ready = vt[i].ordy;
      end
      @(negedge clk);
      in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;

      // Exhaustive sweep, four pairs per window, against an integer model
      mg = 0; me = 0; ml = 0; mm = 0; n = 0;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            push(ia, ib);
            if (ia > ib) mg++; else if (ia == ib) me++; else ml++;
            if (n == 0 || ia > mm) mm = ia;
            n++;
            if (n == 4) begin
               chk_all($sformatf("sweep_a%0d_b%0d", ia, ib), 0, 1, mg, me, ml, MAXON ? mm : 0);
               out_ready = 1'b1;
               @(negedge clk);
               out_ready = 1'b0;
               mg = 0; me = 0; ml = 0; mm = 0; n = 0;
            end
         end
      end

      // Reset after three accepts discards the partial window
      push(5, 1); push(5, 1); push(5, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_all("rst_mid", 1, 0, 0, 0, 0, 0);
      push(1, 9); push(1, 9); push(1, 9);
      chk("rst_3new.out_valid", int'(out_valid), 0);
      push(1, 9);
      chk_all("rst_4new", 0, 1, 0, 0, 4, MAXON ? 1 : 0);

      // Reset while a result is pending drops it
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk_all("rst_hold", 1, 0, 0, 0, 0, 0);

      // WIN=1: each accept completes a window
      @(negedge clk);
      w1_valid = 1'b1; w1_a = 4'd7; w1_b = 4'd3;
      @(negedge clk);
      w1_valid = 1'b0;
      chk("w1.out_valid", int'(w1_ovalid), 1);
      chk("w1.in_ready", int'(w1_ready), 0);
      chk("w1.sum", int'(w1_gt) + int'(w1_eq) + int'(w1_lt), 1);
      chk("w1.gt", int'(w1_gt), 1);
      chk("w1.max", int'(w1_max), MAXON ? 7 : 0);
      w1_oready = 1'b1;
      @(negedge clk);
      w1_oready = 1'b0;
      w1_valid = 1'b1; w1_a = 4'd2; w1_b = 4'd2;
      @(negedge clk);
      w1_valid = 1'b0;
      chk("w1b.out_valid", int'(w1_ovalid), 1);
      chk("w1b.eq", int'(w1_eq), 1);
      chk("w1b.sum", int'(w1_gt) + int'(w1_eq) + int'(w1_lt), 1);
      chk("w1b.max", int'(w1_max), MAXON ? 2 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mc_window_stats

// File: doc/mc_window_stats.md
MC_WINDOW_STATS -- requirements
Module: mc_window_stats

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits.
REQ-002 Parameter WIN, default 8: number of operand pairs per window, range 1..255.
REQ-003 Parameter CNT_W, default 8: counter width; SHALL satisfy WIN <= 2^CNT_W-1, checked at elaboration.
REQ-004 clk  input  1  rising-edge clock; sole clock.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair a/b valid.
REQ-007 in_ready  output  1  block accepts a pair this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 clear  input  1  discard partial window.
REQ-011 out_valid  output  1  window result valid.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 gt_cnt, eq_cnt, lt_cnt  output  CNT_W each  count of pairs with a>b, a==b, a<b in the window.
REQ-014 max_a  output  WIDTH  largest a in the window (see Configuration).

Function
REQ-015 Comparison SHALL be unsigned magnitude over WIDTH bits; each accepted pair increments exactly one of gt/eq/lt.
REQ-016 Accept occurs when in_valid && in_ready on a rising clk edge.
REQ-017 FSM states are ACCUM and HOLD; in_ready = (state==ACCUM), out_valid = (state==HOLD), both registered-state decodes with no combinational path from out_ready.
REQ-018 ACCUM: each accept increments the internal sample counter; the accept of sample number WIN moves to HOLD on the same edge, and its compare result is included in the counts.
REQ-019 Latency: out_valid SHALL assert the cycle after the WIN-th accept.
REQ-020 HOLD: gt_cnt/eq_cnt/lt_cnt/max_a SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 HOLD with out_ready=1: counters, sample count and max_a are zeroed and the FSM returns to ACCUM; in_ready is 1 the next cycle (one bubble per window).
REQ-022 clear in ACCUM zeroes counters, sample count and max_a; clear takes priority over a same-cycle accept, which is dropped.
REQ-023 clear in HOLD SHALL be ignored; the pending result is not lost.
REQ-024 Counts are observable during ACCUM as running totals; their values there are informational only.
REQ-025 WIN=1: every accept goes straight to HOLD; the sum of the counts is then 1.

Reset
REQ-026 While rst=0 at a clk edge: state=ACCUM, in_ready=1 the next cycle, out_valid=0, all counts=0, max_a=0, sample count=0.
REQ-027 Reset mid-window or in HOLD SHALL discard all partial or pending results.

Configuration
REQ-028 Macro MC_WINDOW_MAX_EN defined: max_a tracks the maximum a accepted in the current window; the first sample after clear/reset/handoff loads unconditionally.
REQ-029 Macro MC_WINDOW_MAX_EN undefined: max_a tied to 0 and no tracking register is synthesized; all other behaviour is identical.

Structure
REQ-030 Shared package mc_pkg holds the FSM state encoding (ACCUM=1'b0, HOLD=1'b1) and the default WIDTH/WIN/CNT_W constants.
REQ-031 One combinational sub-module mc_cmp_core (inputs a, b; outputs gt, eq, lt, one-hot) performs the compare; all sequential logic stays in mc_window_stats.

Verification (WIDTH=4, WIN=4, CNT_W=8)
REQ-032 Reset, then pairs (9,3),(5,5),(2,7),(15,0) back-to-back -> out_valid 1 cycle after 4th accept; gt=2, eq=1, lt=1, max_a=15 (0 without macro).
REQ-033 Result pending, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next cycle in_ready=1, counts=0.
REQ-034 Two pairs accepted, then clear with a simultaneous valid pair (3,3) -> counts 0 and (3,3) not counted; the next 4 pairs alone form the window.
REQ-035 clear=1 during HOLD -> result unchanged and still delivered on out_ready.
REQ-036 rst=0 after 3 accepts -> all outputs 0; a fresh window needs 4 new accepts.
REQ-037 Exhaustive 0..15 x 0..15 sweep in windows of 4, scoreboarded against an integer model -> every window's counts and max_a match.
